// File: rtl/lfsr_sequencer_pkg.sv
// rtl/lfsr_sequencer_pkg.sv - shared types and constants for the LFSR sequencer
package lfsr_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  localparam logic [7:0] LFSR_RESET = 8'h01;
  // Feedback taps q[4], q[3], q[2], q[0] for x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_TAPS  = 8'b0001_1101;

endpackage

// File: rtl/lfsr_sequencer_if.sv
// rtl/lfsr_sequencer_if.sv - control and status bundle between board I/O and the sequencer
interface lfsr_sequencer_if;
  logic [7:0] seed;
  logic       load;
  logic       step;
  logic       run;
  logic [7:0] q;
  logic       adv;
  logic       lockup;
  logic [7:0] period;
  logic       wrap;

  modport master (
    output seed, load, step, run,
    input  q, adv, lockup, period, wrap
  );

  modport slave (
    input  seed, load, step, run,
    output q, adv, lockup, period, wrap
  );
endinterface

// File: rtl/lfsr8_next.sv
// rtl/lfsr8_next.sv - combinational advance function of the 8-bit Fibonacci LFSR
module lfsr8_next
  import lfsr_seq_pkg::*;
(
  input  logic [7:0] cur,
  output logic [7:0] nxt
);

  assign nxt = {^(cur & LFSR_TAPS), cur[7:1]};

endmodule

// File: rtl/lfsr_sequencer.sv
// rtl/lfsr_sequencer.sv - LFSR state owner: prescaled run, button step, switch reload.
// Define LFSR_SEQ_PERIOD_EN to build the period counter and wrap pulse.
module lfsr_sequencer
  import lfsr_seq_pkg::*;
#(
  parameter int PRESCALE = 50_000_000
) (
  input  logic           clk,
  input  logic           rst,
  lfsr_sequencer_if.slave bus
);

  localparam int            PW      = $clog2(PRESCALE);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  state_t        state;
  logic [7:0]    q_r;
  logic [7:0]    q_next;
  logic [7:0]    load_val;
  logic          adv_r;
  logic          lock_r;
  logic          step_q;
  logic          step_edge;
  logic          advance;
  logic [PW-1:0] ps_cnt;

  lfsr8_next u_next (
    .cur (q_r),
    .nxt (q_next)
  );

  assign step_edge = bus.step & ~step_q;
  assign load_val  = (bus.seed == 8'h00) ? LFSR_RESET : bus.seed;

  // Load beats everything; a run request in IDLE swallows a coincident step edge.
  always_comb begin
    advance = 1'b0;
    if (!bus.load) begin
      if (state == S_IDLE)
        advance = !bus.run && step_edge;
      else if (state == S_RUN)
        advance = bus.run && (ps_cnt == PS_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      q_r    <= LFSR_RESET;
      adv_r  <= 1'b0;
      lock_r <= 1'b0;
      step_q <= 1'b0;
      ps_cnt <= '0;
    end else begin
      step_q <= bus.step;
      adv_r  <= advance;
      if (advance)
        q_r <= q_next;
      if (bus.load) begin
        state  <= S_LOAD;
        q_r    <= load_val;
        lock_r <= (bus.seed == 8'h00);
        ps_cnt <= '0;
      end else begin
        case (state)
          S_LOAD: begin
            ps_cnt <= '0;
            state  <= bus.run ? S_RUN : S_IDLE;
          end
          S_IDLE: begin
            if (bus.run) begin
              state  <= S_RUN;
              ps_cnt <= '0;
            end
          end
          S_RUN: begin
            if (!bus.run) begin
              state  <= S_IDLE;
              ps_cnt <= '0;
            end else if (ps_cnt == PS_LAST)
              ps_cnt <= '0;
            else
              ps_cnt <= ps_cnt + PW'(1);
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.q      = q_r;
  assign bus.adv    = adv_r;
  assign bus.lockup = lock_r;

`ifdef LFSR_SEQ_PERIOD_EN
  logic [7:0] seed_r;
  logic [7:0] step_cnt;
  logic [7:0] period_r;
  logic       wrap_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_r   <= LFSR_RESET;
      step_cnt <= 8'h00;
      period_r <= 8'h00;
      wrap_r   <= 1'b0;
    end else begin
      wrap_r <= 1'b0;
      if (bus.load) begin
        seed_r   <= load_val;
        step_cnt <= 8'h00;
      end else if (state == S_LOAD) begin
        step_cnt <= 8'h00;
      end else if (advance) begin
        if (q_next == seed_r) begin
          period_r <= step_cnt + 8'd1;
          wrap_r   <= 1'b1;
          step_cnt <= 8'h00;
        end else begin
          step_cnt <= step_cnt + 8'd1;
        end
      end
    end
  end

  assign bus.period = period_r;
  assign bus.wrap   = wrap_r;
`else
  assign bus.period = 8'h00;
  assign bus.wrap   = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_sequencer.sv
// tb/tb_lfsr_sequencer.sv - scoreboard bench for lfsr_sequencer with PRESCALE=4
module tb_lfsr_sequencer;
  import lfsr_seq_pkg::*;

  localparam int PS = 4;

  typedef struct packed {
    logic [7:0]  q;
    logic        wrap;
    logic [7:0]  period;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  int   m_q, m_seed, m_cnt, m_period;
  logic m_lock;

  lfsr_sequencer_if bus ();

  lfsr_sequencer #(.PRESCALE(PS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Shift right by one, new MSB = parity of bits 4,3,2,0
  function automatic int model_next(input int v);
    int fb;
    fb = ((v >> 4) + (v >> 3) + (v >> 2) + v) % 2;
    return (v / 2) + fb * 128;
  endfunction

  task automatic model_reset();
    m_q = 1; m_seed = 1; m_cnt = 0; m_period = 0; m_lock = 1'b0;
  endtask

  task automatic model_advance(input int at_cyc);
    exp_t e;
    logic w;
    m_q = model_next(m_q);
    w = 1'b0;
`ifdef LFSR_SEQ_PERIOD_EN
    if (m_q == m_seed) begin
      m_period = m_cnt + 1;
      m_cnt = 0;
      w = 1'b1;
    end else begin
      m_cnt++;
    end
`endif
    e.q = m_q[7:0]; e.wrap = w; e.period = m_period[7:0]; e.cyc = at_cyc;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.adv) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_adv actual_q=%0h required=no_adv", bus.q);
        end else begin
          e = sbq.pop_front();
          chk("adv_q", bus.q, e.q);
          chk("adv_cycle", cyc, e.cyc);
          chk("adv_wrap", bus.wrap, e.wrap);
          chk("adv_period", bus.period, e.period);
        end
      end else if (bus.wrap) begin
        checks++; errors++;
        $display("FAIL wrap_without_adv actual=1 required=0");
      end
    end
  end

  task automatic do_step(input int hold);
    @(negedge clk);
    bus.step = 1'b1;
    model_advance(cyc + 1);
    repeat (hold) @(negedge clk);
    bus.step = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] s);
    @(negedge clk);
    bus.seed = s;
    bus.load = 1'b1;
    m_q = (s == 8'h00) ? 1 : int'(s);
    m_lock = (s == 8'h00);
    m_seed = m_q;
    m_cnt = 0;
    @(negedge clk);
    bus.load = 1'b0;
    chk("load_q", bus.q, m_q);
    chk("load_lockup", bus.lockup, m_lock);
    @(negedge clk);
  endtask

  task automatic do_run(input int r);
    int c;
    @(negedge clk);
    bus.run = 1'b1;
    c = cyc;
    for (int j = 1; PS * j <= r - 1; j++)
      model_advance(c + 1 + PS * j);
    repeat (r) @(negedge clk);
    bus.run = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.seed = 8'h00; bus.load = 1'b0; bus.step = 1'b0; bus.run = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_q", bus.q, 8'h01);
    chk("reset_adv", bus.adv, 1'b0);
    chk("reset_lockup", bus.lockup, 1'b0);
    chk("reset_period", bus.period, 8'h00);
    chk("reset_wrap", bus.wrap, 1'b0);

    do_step(1);
    chk("step1_q", bus.q, 8'h80);
    do_step(4);
    chk("step2_held_q", bus.q, 8'h40);

    do_load(8'h00);
    chk("zero_seed_lockup", bus.lockup, 1'b1);
    do_load(8'h5A);
    chk("nonzero_seed_q", bus.q, 8'h5A);

    do_load(8'h01);
    do_run(13);
    chk("run_q", bus.q, 8'h20);
    do_run(6);
    chk("run_drop_q", bus.q, 8'h10);

    // Load and a step edge in the same cycle: the step must be dropped
    @(negedge clk);
    bus.seed = 8'h33; bus.load = 1'b1; bus.step = 1'b1;
    m_q = 8'h33; m_lock = 1'b0; m_seed = 8'h33; m_cnt = 0;
    @(negedge clk);
    bus.load = 1'b0;
    chk("load_step_q", bus.q, 8'h33);
    @(negedge clk);
    bus.step = 1'b0;
    @(negedge clk);
    do_step(1);
    chk("after_load_step_q", bus.q, 8'h19);

    do_load(8'h01);
    for (int i = 0; i < 255; i++) do_step(1);
    chk("full_period_q", bus.q, 8'h01);
`ifdef LFSR_SEQ_PERIOD_EN
    chk("full_period_period", bus.period, 8'hFF);
`else
    chk("period_tied_zero", bus.period, 8'h00);
`endif

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: do_step($urandom_range(1, 3));
        1: do_load(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
        default: do_run($urandom_range(1, 14));
      endcase
    end

    // Asynchronous reset mid-count in RUN
    do_load(8'h00);
    @(negedge clk);
    bus.run = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_q", bus.q, 8'h01);
    chk("async_rst_lockup", bus.lockup, 1'b0);
    chk("async_rst_adv", bus.adv, 1'b0);
    chk("async_rst_state", 32'(dut.state), 32'(S_IDLE));
    model_reset();
    @(negedge clk);
    bus.run = 1'b0;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    do_step(1);
    chk("post_rst_step_q", bus.q, 8'h80);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_sequencer.md
# lfsr_sequencer

Controller for the 8-bit Fibonacci LFSR datapath on the board experiments. It owns the LFSR state register and decides when the register advances:
- free-running from a prescaled clock tick,
- single-stepped from a push-button edge,
- reloaded from switches.

It guards against the all-zero lock-up state and, optionally, measures the sequence period. The outputs feed the existing two-digit seven-segment display path.

## Interface
- PRESCALE, default 50_000_000: clocks per automatic advance in RUN (≥2). Counter width is $clog2(PRESCALE).
- clk  input  1  rising-edge system clock
- rst  input  1  asynchronous, active-high reset
- seed  input  8  seed value from switches
- load  input  1  level; while high, the register is (re)loaded every cycle
- step  input  1  raw push-button level; each rising edge advances once in IDLE
- run  input  1  level; high selects free-running mode
- q  output  8  current LFSR state
- adv  output  1  one-cycle pulse, high in the cycle a new advanced q is first visible
- lockup  output  1  sticky flag: a zero seed was corrected
- period  output  8  last measured period (PERIOD_EN only; otherwise tied 0)
- wrap  output  1  one-cycle pulse when the sequence returns to the loaded seed (PERIOD_EN only; otherwise tied 0)

## Operation
- Advance function: next = {q[4]^q[3]^q[2]^q[0], q[7:1]}. This is polynomial x^8+x^6+x^5+x^4+1, a maximal sequence of period 255 for any nonzero state.
- Reset values: q=8'h01, adv=0, lockup=0, period=0, wrap=0, state=S_IDLE, prescaler=0, step edge register=0, step count=0, stored seed=8'h01.
- Step edge: step & ~step_q, where step_q is step registered each cycle.
- States:
  - S_IDLE: each step edge advances once. A held button gives exactly one advance.
  - S_RUN: the prescaler counts 0..PRESCALE-1. The register advances when count==PRESCALE-1, then the count returns to 0. Step edges are ignored.
  - S_LOAD: q holds its value; the prescaler and step count are cleared.
- Transitions:
  - load=1 from any state → S_LOAD, with q ← seed, or 8'h01 if seed==0.
  - S_LOAD with load=0 → S_RUN if run=1, else S_IDLE.
  - S_IDLE with run=1 → S_RUN, prescaler cleared.
  - S_RUN with run=0 → S_IDLE, prescaler cleared.
- Priority: load > run/prescaler > step. When load and a step edge occur in the same cycle, the step is dropped.
- lockup:
  - Set by a load with seed==0.
  - Cleared by a load with a nonzero seed, or by rst.
  - q can never become 0.

## Timing
- Step edge sampled at clock edge k: q updates at edge k, and adv is high from edge k to edge k+1.
- RUN entered at edge k: the first advance happens at edge k+PRESCALE, then one advance every PRESCALE cycles.
- Load sampled at edge k: q = seed after edge k. With PERIOD_EN, the stored seed is captured at the same edge.
- run dropping mid-count discards the partial count. Re-entering RUN restarts a full PRESCALE interval.
- rst asserts asynchronously mid-operation: all registers take reset values immediately, independent of clk.

## Configuration
- LFSR_SEQ_PERIOD_EN defined:
  - An 8-bit step count increments on each advance.
  - When the next value equals the stored seed, the block latches period ← count+1, pulses wrap together with adv, and clears the count.
  - A load clears the count but not period.
- Not defined: no counter or seed register is built; period=0 and wrap=0 constantly.

## Structure
- Package lfsr_seq_pkg holds:
  - the state enum (S_IDLE, S_RUN, S_LOAD);
  - LFSR_RESET = 8'h01;
  - the tap constants.
- Sub-module lfsr8_next: the purely combinational advance function, shared with verification models.
- Display decoding stays outside this block, using the existing seven-segment decoder.

## Test plan
- Reset, then one step edge in IDLE → q: 01 → 80. A second edge gives 40. adv pulses once per edge; holding step high gives no further advances.
- load=1 with seed=00 → q=01, lockup=1. Then load with seed=5A → q=5A, lockup=0.
- PRESCALE=4, run=1 from q=01 → q becomes 80, 40, 20 at 4, 8, 12 cycles after RUN entry. Dropping run at cycle 2 of an interval gives no advance.
- load and a step edge in the same cycle with seed=33 → q=33 and no adv. The next step edge gives 19.
- PERIOD_EN, seed=01, 255 step edges → wrap pulses on the 255th advance, with q=01 and period=FF.
- rst asserted between clock edges while in RUN → q=01, state IDLE, lockup=0 immediately. No advance occurs until a new step edge or run.
